// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// bsg_manycore_link_to_axil_pkg: shared constants for the manycore link host serdes.
//   Lane indices for the host (TX) side and the manycore (RX) side, the default
//   beats-per-packet constant, and a helper sizing beat counters.
package bsg_manycore_link_to_axil_pkg;
    localparam int mcl_beats_per_pkt_gp  = 4;
    localparam int mcl_host_req_lane_gp  = 0;
    localparam int mcl_host_resp_lane_gp = 1;
    localparam int mcl_mc_resp_lane_gp   = 0;
    localparam int mcl_mc_req_lane_gp    = 1;
    function automatic int mcl_cnt_width(input int beats);
        return beats > 1 ? $clog2(beats) : 1;
    endfunction
endpackage

// File: rtl/bsg_mcl_word_packer.sv
// bsg_mcl_word_packer: one TX lane, packs host beats (beat 0 = LSW) into a packet.
//   clk_i, reset_n_i (async active-low), clear_i (sync flush)
//   v_i/data_i/ready_o : host beat in
//   v_o/data_o/ready_i : packed packet out
//   partial_o          : lane holds 1..beats-1 beats
module bsg_mcl_word_packer
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int fifo_width_p = 128,
    parameter int host_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    clear_i,
    input  logic                    v_i,
    input  logic [host_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [fifo_width_p-1:0] data_o,
    input  logic                    ready_i,
    output logic                    partial_o
);
    localparam int beats_lp = fifo_width_p / host_width_p;
    localparam int cnt_w_lp = mcl_cnt_width(beats_lp);
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic                    full_q, full_d;
    logic [fifo_width_p-1:0] data_q, data_d;
    logic                    in_hs, out_hs, last;
    always_comb begin
        in_hs  = v_i & ~full_q & ~clear_i;
        out_hs = full_q & ready_i & ~clear_i;
        last   = cnt_q == cnt_w_lp'(beats_lp - 1);
        cnt_d  = clear_i ? '0 : in_hs ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        full_d = clear_i ? 1'b0 : (in_hs & last) | (full_q & ~out_hs);
        data_d = data_q;
        for (int k = 0; k < beats_lp; k++)
            if (in_hs && cnt_q == cnt_w_lp'(k)) data_d[k*host_width_p +: host_width_p] = data_i;
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            data_q <= data_d;
        end
    end
    assign ready_o   = ~full_q;
    assign v_o       = full_q;
    assign data_o    = data_q;
    assign partial_o = cnt_q != '0;
endmodule

// File: rtl/bsg_mcl_host_serdes.sv
// bsg_mcl_host_serdes: host beat <-> manycore packet serdes, two TX and two RX lanes.
//   clk_i, reset_n_i (async active-low), clear_i (sync flush of all lanes)
//   TX: host_v_i/host_data_i/host_ready_o -> fifo_v_o/fifo_data_o/fifo_ready_i
//   RX: fifo_v_i/fifo_data_i/fifo_ready_o -> host_v_o/host_data_o/host_ready_i
//   status: tx_partial_o, rx_words_o; tx_pkt_cnt_o/rx_pkt_cnt_o packet counters
//   Optional: BSG_MCL_SERDES_PKT_COUNTERS_EN enables the packet counters (else tied 0).
module bsg_mcl_host_serdes
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int fifo_width_p = 128,
    parameter int host_width_p = 32,
    localparam int beats_lp = fifo_width_p / host_width_p,
    localparam int rx_w_lp  = $clog2(beats_lp + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         clear_i,
    input  logic [1:0]                   host_v_i,
    input  logic [1:0][host_width_p-1:0] host_data_i,
    output logic [1:0]                   host_ready_o,
    output logic [1:0]                   fifo_v_o,
    output logic [1:0][fifo_width_p-1:0] fifo_data_o,
    input  logic [1:0]                   fifo_ready_i,
    input  logic [1:0]                   fifo_v_i,
    input  logic [1:0][fifo_width_p-1:0] fifo_data_i,
    output logic [1:0]                   fifo_ready_o,
    output logic [1:0]                   host_v_o,
    output logic [1:0][host_width_p-1:0] host_data_o,
    input  logic [1:0]                   host_ready_i,
    output logic [1:0]                   tx_partial_o,
    output logic [1:0][rx_w_lp-1:0]      rx_words_o,
    output logic [1:0][31:0]             tx_pkt_cnt_o,
    output logic [1:0][31:0]             rx_pkt_cnt_o
);
    localparam int cnt_w_lp = mcl_cnt_width(beats_lp);
    for (genvar l = 0; l < 2; l++) begin : tx
        bsg_mcl_word_packer #(.fifo_width_p(fifo_width_p), .host_width_p(host_width_p)) packer (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .clear_i  (clear_i),
            .v_i      (host_v_i[l]),
            .data_i   (host_data_i[l]),
            .ready_o  (host_ready_o[l]),
            .v_o      (fifo_v_o[l]),
            .data_o   (fifo_data_o[l]),
            .ready_i  (fifo_ready_i[l]),
            .partial_o(tx_partial_o[l])
        );
    end
    for (genvar l = 0; l < 2; l++) begin : rx
        logic                    valid_q, valid_d;
        logic [cnt_w_lp-1:0]     idx_q, idx_d;
        logic [fifo_width_p-1:0] data_q, data_d;
        logic                    in_hs, out_hs, last;
        always_comb begin
            in_hs   = fifo_v_i[l] & ~valid_q & ~clear_i;
            out_hs  = valid_q & host_ready_i[l] & ~clear_i;
            last    = idx_q == cnt_w_lp'(beats_lp - 1);
            valid_d = clear_i ? 1'b0 : in_hs | (valid_q & ~(out_hs & last));
            idx_d   = (clear_i | in_hs) ? '0 : out_hs ? (last ? '0 : idx_q + 1'b1) : idx_q;
            data_d  = in_hs ? fifo_data_i[l] : data_q;
        end
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                idx_q   <= idx_d;
                data_q  <= data_d;
            end
        end
        assign fifo_ready_o[l] = ~valid_q;
        assign host_v_o[l]     = valid_q;
        assign host_data_o[l]  = data_q[idx_q*host_width_p +: host_width_p];
        assign rx_words_o[l]   = valid_q ? rx_w_lp'(beats_lp) - rx_w_lp'(idx_q) : '0;
    end
`ifdef BSG_MCL_SERDES_PKT_COUNTERS_EN
    logic [1:0][31:0] tx_cnt_q, rx_cnt_q;
    // Handshakes swallowed by clear_i are not counted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (fifo_v_o[l] & fifo_ready_i[l] & ~clear_i) tx_cnt_q[l] <= tx_cnt_q[l] + 32'd1;
                if (fifo_v_i[l] & fifo_ready_o[l] & ~clear_i) rx_cnt_q[l] <= rx_cnt_q[l] + 32'd1;
            end
        end
    end
    assign tx_pkt_cnt_o = tx_cnt_q;
    assign rx_pkt_cnt_o = rx_cnt_q;
`else
    assign tx_pkt_cnt_o = '0;
    assign rx_pkt_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bsg_mcl_host_serdes.sv
// tb_bsg_mcl_host_serdes: directed self-checking bench for bsg_mcl_host_serdes.
module tb_bsg_mcl_host_serdes;
    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [1:0]        host_v_i = '0;
    logic [1:0][31:0]  host_data_i = '0;
    logic [1:0]        host_ready_o;
    logic [1:0]        fifo_v_o;
    logic [1:0][127:0] fifo_data_o;
    logic [1:0]        fifo_ready_i = '0;
    logic [1:0]        fifo_v_i = '0;
    logic [1:0][127:0] fifo_data_i = '0;
    logic [1:0]        fifo_ready_o;
    logic [1:0]        host_v_o;
    logic [1:0][31:0]  host_data_o;
    logic [1:0]        host_ready_i = '0;
    logic [1:0]        tx_partial_o;
    logic [1:0][2:0]   rx_words_o;
    logic [1:0][31:0]  tx_pkt_cnt_o, rx_pkt_cnt_o;
    int errors = 0;
    int checks = 0;

    bsg_mcl_host_serdes dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_i),
        .host_v_i(host_v_i), .host_data_i(host_data_i), .host_ready_o(host_ready_o),
        .fifo_v_o(fifo_v_o), .fifo_data_o(fifo_data_o), .fifo_ready_i(fifo_ready_i),
        .fifo_v_i(fifo_v_i), .fifo_data_i(fifo_data_i), .fifo_ready_o(fifo_ready_o),
        .host_v_o(host_v_o), .host_data_o(host_data_o), .host_ready_i(host_ready_i),
        .tx_partial_o(tx_partial_o), .rx_words_o(rx_words_o),
        .tx_pkt_cnt_o(tx_pkt_cnt_o), .rx_pkt_cnt_o(rx_pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic send(input int lane, input logic [31:0] d);
        host_v_i[lane] = 1'b1;
        host_data_i[lane] = d;
        @(posedge clk_i); #1;
        host_v_i[lane] = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (host_ready_o !== 2'b11) begin errors++; $display("FAIL reset host_ready_o got %b want 11", host_ready_o); end
        checks++; if (fifo_ready_o !== 2'b11) begin errors++; $display("FAIL reset fifo_ready_o got %b want 11", fifo_ready_o); end
        checks++; if (fifo_v_o !== 2'b00) begin errors++; $display("FAIL reset fifo_v_o got %b want 00", fifo_v_o); end
        checks++; if (host_v_o !== 2'b00) begin errors++; $display("FAIL reset host_v_o got %b want 00", host_v_o); end
        checks++; if (fifo_data_o !== '0) begin errors++; $display("FAIL reset fifo_data_o got %h want 0", fifo_data_o); end
        checks++; if (host_data_o !== '0) begin errors++; $display("FAIL reset host_data_o got %h want 0", host_data_o); end
        checks++; if (tx_partial_o !== 2'b00) begin errors++; $display("FAIL reset tx_partial_o got %b want 00", tx_partial_o); end
        checks++; if (rx_words_o !== '0) begin errors++; $display("FAIL reset rx_words_o got %h want 0", rx_words_o); end
        checks++; if (tx_pkt_cnt_o !== '0 || rx_pkt_cnt_o !== '0) begin errors++; $display("FAIL reset counters got %h/%h want 0", tx_pkt_cnt_o, rx_pkt_cnt_o); end
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_tx_lane0;
        for (int k = 0; k < 4; k++) begin
            send(0, 32'h11111111 * (k + 1));
            if (k < 3) begin
                checks++; if (tx_partial_o[0] !== 1'b1) begin errors++; $display("FAIL tx0 partial beat %0d got %b want 1", k, tx_partial_o[0]); end
                checks++; if (fifo_v_o[0] !== 1'b0) begin errors++; $display("FAIL tx0 early fifo_v beat %0d got %b want 0", k, fifo_v_o[0]); end
            end
        end
        checks++; if (fifo_v_o[0] !== 1'b1) begin errors++; $display("FAIL tx0 fifo_v got %b want 1", fifo_v_o[0]); end
        checks++; if (fifo_data_o[0] !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL tx0 data got %h want 44444444333333332222222211111111", fifo_data_o[0]); end
        checks++; if (tx_partial_o[0] !== 1'b0) begin errors++; $display("FAIL tx0 partial full got %b want 0", tx_partial_o[0]); end
        checks++; if (host_ready_o[0] !== 1'b0) begin errors++; $display("FAIL tx0 ready full got %b want 0", host_ready_o[0]); end
        fifo_ready_i[0] = 1'b1;
        @(posedge clk_i); #1;
        fifo_ready_i[0] = 1'b0;
        checks++; if (fifo_v_o[0] !== 1'b0) begin errors++; $display("FAIL tx0 fifo_v after hs got %b want 0", fifo_v_o[0]); end
        checks++; if (host_ready_o[0] !== 1'b1) begin errors++; $display("FAIL tx0 ready after hs got %b want 1", host_ready_o[0]); end
    endtask

    task automatic test_tx_backpressure;
        logic [127:0] exp_pkt;
        for (int k = 0; k < 4; k++) begin
            exp_pkt[k*32 +: 32] = 32'hA0000000 + k;
            send(1, 32'hA0000000 + k);
        end
        host_v_i[1] = 1'b1;
        host_data_i[1] = 32'hDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            checks++; if (host_ready_o[1] !== 1'b0) begin errors++; $display("FAIL bp ready cyc %0d got %b want 0", c, host_ready_o[1]); end
            checks++; if (fifo_v_o[1] !== 1'b1 || fifo_data_o[1] !== exp_pkt) begin errors++; $display("FAIL bp data cyc %0d got v=%b %h want v=1 %h", c, fifo_v_o[1], fifo_data_o[1], exp_pkt); end
        end
        host_v_i[1] = 1'b0;
        fifo_ready_i[1] = 1'b1;
        @(posedge clk_i); #1;
        fifo_ready_i[1] = 1'b0;
        checks++; if (fifo_v_o[1] !== 1'b0) begin errors++; $display("FAIL bp fifo_v after hs got %b want 0", fifo_v_o[1]); end
        checks++; if (host_ready_o[1] !== 1'b1) begin errors++; $display("FAIL bp ready after hs got %b want 1", host_ready_o[1]); end
        checks++; if (tx_partial_o[1] !== 1'b0) begin errors++; $display("FAIL bp partial got %b want 0", tx_partial_o[1]); end
    endtask

    task automatic test_rx_lane0;
        logic [127:0] pkt;
        pkt = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
        checks++; if (fifo_ready_o[0] !== 1'b1) begin errors++; $display("FAIL rx0 ready idle got %b want 1", fifo_ready_o[0]); end
        fifo_v_i[0] = 1'b1;
        fifo_data_i[0] = pkt;
        @(posedge clk_i); #1;
        fifo_v_i[0] = 1'b0;
        fifo_data_i[0] = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            checks++; if (host_v_o[0] !== 1'b1 || host_data_o[0] !== pkt[k*32 +: 32]) begin errors++; $display("FAIL rx0 beat %0d got v=%b %h want v=1 %h", k, host_v_o[0], host_data_o[0], pkt[k*32 +: 32]); end
            checks++; if (rx_words_o[0] !== 3'(4 - k)) begin errors++; $display("FAIL rx0 words beat %0d got %0d want %0d", k, rx_words_o[0], 4 - k); end
            checks++; if (fifo_ready_o[0] !== 1'b0) begin errors++; $display("FAIL rx0 ready busy beat %0d got %b want 0", k, fifo_ready_o[0]); end
            host_ready_i[0] = 1'b1;
            @(posedge clk_i); #1;
            host_ready_i[0] = 1'b0;
        end
        checks++; if (host_v_o[0] !== 1'b0) begin errors++; $display("FAIL rx0 v after drain got %b want 0", host_v_o[0]); end
        checks++; if (rx_words_o[0] !== 3'd0) begin errors++; $display("FAIL rx0 words after drain got %0d want 0", rx_words_o[0]); end
        checks++; if (fifo_ready_o[0] !== 1'b1) begin errors++; $display("FAIL rx0 ready after drain got %b want 1", fifo_ready_o[0]); end
    endtask

    task automatic test_clear;
        send(0, 32'hAAAA0001);
        send(0, 32'hAAAA0002);
        fifo_v_i[1] = 1'b1;
        fifo_data_i[1] = 128'h1;
        @(posedge clk_i); #1;
        fifo_v_i[1] = 1'b0;
        checks++; if (tx_partial_o[0] !== 1'b1) begin errors++; $display("FAIL clr partial before got %b want 1", tx_partial_o[0]); end
        checks++; if (host_v_o[1] !== 1'b1) begin errors++; $display("FAIL clr rx1 loaded got %b want 1", host_v_o[1]); end
        clear_i = 1'b1;
        host_v_i[0] = 1'b1;
        host_data_i[0] = 32'h00000BAD;
        fifo_v_i[0] = 1'b1;
        fifo_data_i[0] = 128'hBAD;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        host_v_i[0] = 1'b0;
        fifo_v_i[0] = 1'b0;
        checks++; if (tx_partial_o[0] !== 1'b0) begin errors++; $display("FAIL clr partial after got %b want 0", tx_partial_o[0]); end
        checks++; if (host_v_o !== 2'b00) begin errors++; $display("FAIL clr host_v_o got %b want 00", host_v_o); end
        checks++; if (fifo_ready_o !== 2'b11 || rx_words_o !== '0) begin errors++; $display("FAIL clr rx state got ready=%b words=%h want 11/0", fifo_ready_o, rx_words_o); end
        for (int k = 0; k < 4; k++) send(0, 32'hC0 + k);
        checks++; if (fifo_v_o[0] !== 1'b1 || fifo_data_o[0] !== 128'h000000C3_000000C2_000000C1_000000C0) begin errors++; $display("FAIL clr clean pkt got v=%b %h want v=1 000000c3000000c2000000c1000000c0", fifo_v_o[0], fifo_data_o[0]); end
        fifo_ready_i[0] = 1'b1;
        @(posedge clk_i); #1;
        fifo_ready_i[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [127:0] p1, p2;
        for (int k = 0; k < 4; k++) begin
            p1[k*32 +: 32] = 32'h10000000 + k;
            p2[k*32 +: 32] = 32'h20000000 + k;
        end
        fifo_v_i[1] = 1'b1;
        fifo_data_i[1] = p1;
        host_ready_i[1] = 1'b1;
        @(posedge clk_i); #1;
        fifo_data_i[1] = p2;
        for (int k = 0; k < 4; k++) begin
            checks++; if (host_v_o[1] !== 1'b1 || host_data_o[1] !== p1[k*32 +: 32]) begin errors++; $display("FAIL b2b p1 beat %0d got v=%b %h want v=1 %h", k, host_v_o[1], host_data_o[1], p1[k*32 +: 32]); end
            @(posedge clk_i); #1;
        end
        checks++; if (host_v_o[1] !== 1'b0 || fifo_ready_o[1] !== 1'b1) begin errors++; $display("FAIL b2b gap got v=%b ready=%b want 0/1", host_v_o[1], fifo_ready_o[1]); end
        @(posedge clk_i); #1;
        fifo_v_i[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (host_v_o[1] !== 1'b1 || host_data_o[1] !== p2[k*32 +: 32]) begin errors++; $display("FAIL b2b p2 beat %0d got v=%b %h want v=1 %h", k, host_v_o[1], host_data_o[1], p2[k*32 +: 32]); end
            @(posedge clk_i); #1;
        end
        host_ready_i[1] = 1'b0;
        checks++; if (host_v_o[1] !== 1'b0) begin errors++; $display("FAIL b2b drained got v=%b want 0", host_v_o[1]); end
    endtask

    task automatic test_async_reset;
        send(0, 32'h55550000);
        send(0, 32'h55550001);
        for (int k = 0; k < 4; k++) send(1, 32'h66660000 + k);
        fifo_v_i = 2'b11;
        fifo_data_i[0] = 128'h7777;
        fifo_data_i[1] = 128'h8888;
        @(posedge clk_i); #1;
        fifo_v_i = 2'b00;
        checks++; if (tx_partial_o[0] !== 1'b1 || fifo_v_o[1] !== 1'b1 || host_v_o !== 2'b11) begin errors++; $display("FAIL arst preload got partial=%b fifo_v=%b host_v=%b", tx_partial_o, fifo_v_o, host_v_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++; if (host_ready_o !== 2'b11 || fifo_ready_o !== 2'b11) begin errors++; $display("FAIL arst readies got %b/%b want 11/11", host_ready_o, fifo_ready_o); end
        checks++; if (fifo_v_o !== 2'b00 || host_v_o !== 2'b00) begin errors++; $display("FAIL arst valids got %b/%b want 00/00", fifo_v_o, host_v_o); end
        checks++; if (fifo_data_o !== '0 || host_data_o !== '0) begin errors++; $display("FAIL arst data got %h/%h want 0", fifo_data_o, host_data_o); end
        checks++; if (tx_partial_o !== 2'b00 || rx_words_o !== '0) begin errors++; $display("FAIL arst status got %b/%h want 0", tx_partial_o, rx_words_o); end
        #4;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_counters;
        logic [31:0] exp_tx, exp_rx;
`ifdef BSG_MCL_SERDES_PKT_COUNTERS_EN
        force dut.tx_cnt_q = {32'd0, 32'hFFFFFFFE};
        #1;
        release dut.tx_cnt_q;
        exp_tx = 32'd1;
        exp_rx = 32'd1;
`else
        exp_tx = 32'd0;
        exp_rx = 32'd0;
`endif
        fifo_ready_i[0] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) send(0, 32'h900 + p * 4 + k);
            @(posedge clk_i); #1;
        end
        fifo_ready_i[0] = 1'b0;
        fifo_v_i[0] = 1'b1;
        fifo_data_i[0] = 128'h42;
        @(posedge clk_i); #1;
        fifo_v_i[0] = 1'b0;
        host_ready_i[0] = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        host_ready_i[0] = 1'b0;
        checks++; if (tx_pkt_cnt_o[0] !== exp_tx) begin errors++; $display("FAIL cnt tx0 got %h want %h", tx_pkt_cnt_o[0], exp_tx); end
        checks++; if (tx_pkt_cnt_o[1] !== 32'd0) begin errors++; $display("FAIL cnt tx1 got %h want 0", tx_pkt_cnt_o[1]); end
        checks++; if (rx_pkt_cnt_o[0] !== exp_rx) begin errors++; $display("FAIL cnt rx0 got %h want %h", rx_pkt_cnt_o[0], exp_rx); end
        checks++; if (host_v_o[0] !== 1'b0 || fifo_v_o[0] !== 1'b0) begin errors++; $display("FAIL cnt idle got host_v=%b fifo_v=%b want 0/0", host_v_o[0], fifo_v_o[0]); end
    endtask

    initial begin
        test_reset();
        test_tx_lane0();
        test_tx_backpressure();
        test_rx_lane0();
        test_clear();
        test_back_to_back();
        test_async_reset();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bsg_mcl_host_serdes.md
# bsg_mcl_host_serdes

Host-side word serializer/deserializer for the manycore link FIFO pair. It assembles 32-bit host beats into 128-bit request/response packets and feeds them to the FIFO inputs of the manycore endpoint bridge. It also slices 128-bit manycore response/request packets coming from that bridge back into 32-bit host beats. It sits between the AXI-Lite register/FIFO front end and the endpoint bridge.

## Interface
Parameters:
- fifo_width_p, 128, packet width on the endpoint side; must be a multiple of host_width_p.
- host_width_p, 32, host beat width.
- beats_lp (local), fifo_width_p/host_width_p, beats per packet (4 at defaults).

Ports (lane index is 2 bits wide, `[1:0]`; widths are per lane):
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock, asynchronous, active-low.
- clear_i  in  1  synchronous flush of all lanes.
- host_v_i  in  [1:0]  host TX beat valid; lane 0 = host request, lane 1 = host response.
- host_data_i  in  [1:0][host_width_p]  host TX beat.
- host_ready_o  out  [1:0]  TX lane accepts a beat.
- fifo_v_o  out  [1:0]  packed packet valid, to the endpoint bridge fifo_v_i.
- fifo_data_o  out  [1:0][fifo_width_p]  packed packet.
- fifo_ready_i  in  [1:0]  endpoint bridge accepts the packet.
- fifo_v_i  in  [1:0]  packet from the bridge; lane 0 = manycore response, lane 1 = manycore request.
- fifo_data_i  in  [1:0][fifo_width_p]  packet from the bridge.
- fifo_ready_o  out  [1:0]  RX lane accepts a packet.
- host_v_o  out  [1:0]  host RX beat valid.
- host_data_o  out  [1:0][host_width_p]  host RX beat.
- host_ready_i  in  [1:0]  host consumes the beat.
- tx_partial_o  out  [1:0]  TX lane holds 1..beats_lp-1 beats.
- rx_words_o  out  [1:0][$clog2(beats_lp+1)]  RX beats still readable.
- tx_pkt_cnt_o, rx_pkt_cnt_o  out  [1:0][32]  packet counters (see Configuration).

## Operation
- All handshakes are valid/ready. A transfer occurs when both are high at the clock edge.
- TX lane (packer):
  - State: beat counter cnt_r in 0..beats_lp-1, full_r, and a 128-bit data_r.
  - Beat k is written to data_r[k*host_width_p +: host_width_p]. Beat 0 is the least significant word.
  - host_ready_o = ~full_r.
  - On the last beat: cnt_r wraps to 0 and full_r sets.
  - fifo_v_o = full_r, and fifo_data_o = data_r.
  - full_r clears on the fifo handshake.
- RX lane (unpacker):
  - fifo_ready_o = ~valid_r.
  - On the fifo handshake: latch data_r, set idx_r = 0, set valid_r.
  - host_v_o = valid_r, and host_data_o = data_r word idx_r.
  - Each host handshake increments idx_r. The handshake at idx_r = beats_lp-1 clears valid_r and resets idx_r to 0.
- Status outputs:
  - tx_partial_o = (cnt_r != 0).
  - rx_words_o = valid_r ? beats_lp - idx_r : 0.
- clear_i:
  - Zeroes cnt_r, full_r, valid_r and idx_r in every lane.
  - Handshakes in the same cycle are ignored and data is dropped.
  - Counters are not cleared.
- Lanes are fully independent. Simultaneous activity on all four lanes is legal.

## Timing
- Reset (reset_n_i low, asynchronous):
  - All state registers go to 0; data_r goes to 0.
  - Resulting outputs: host_ready_o = 2'b11, fifo_ready_o = 2'b11, all valid outputs 0, all data outputs 0, tx_partial_o = 0, rx_words_o = 0, counters 0.
- Reset asserted mid-packet discards the partial packet immediately.
- TX timing:
  - fifo_v_o rises the cycle after the last beat is accepted.
  - The first beat of the next packet is accepted the cycle after the fifo handshake.
  - Peak rate: beats_lp+1 cycles per packet.
- RX timing:
  - Beat 0 is visible the cycle after the fifo handshake.
  - The next packet is accepted the cycle after the last beat is read.
- No combinational path exists from any *_ready_i input to any *_ready_o output.

## Configuration
- BSG_MCL_SERDES_PKT_COUNTERS_EN defined:
  - tx_pkt_cnt_o[l] increments on each fifo_v_o/fifo_ready_i handshake.
  - rx_pkt_cnt_o[l] increments on each fifo_v_i/fifo_ready_o handshake.
  - Counters are 32-bit, wrap from 0xFFFFFFFF to 0, and reset only with reset_n_i.
- Not defined: both counter ports are tied to 0 and no counter flops are generated.

## Structure
- Lane index constants (host request = 0, host response = 1, manycore response = 0, manycore request = 1) go in bsg_manycore_link_to_axil_pkg.
- The beats-per-packet constant also goes in bsg_manycore_link_to_axil_pkg.
- Sub-module bsg_mcl_word_packer implements one TX lane and is instantiated twice.
- The unpacker is written inline in a generate loop.

## Test plan
- Lane 0 TX: write beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> fifo_data_o[0] = 0x44444444_33333333_22222222_11111111, fifo_v_o[0] rises one cycle after the 4th beat.
- Lane 1 TX with fifo_ready_i[1] held low for 10 cycles after a full packet -> host_ready_o[1] stays 0 and data holds stable; release -> handshake, then host_ready_o[1] = 1 next cycle.
- Lane 0 RX: packet 0xDDDD_CCCC_BBBB_AAAA (32-bit words) with host_ready_i toggling -> beats out in order AAAA, BBBB, CCCC, DDDD; rx_words_o steps 4, 3, 2, 1, 0; fifo_ready_o[0] is 0 until the last beat is read.
- 2 TX beats written, then clear_i pulsed -> tx_partial_o = 0; the next 4 beats form a clean packet containing no stale words.
- reset_n_i dropped mid-packet on all lanes, asynchronously between edges -> outputs reach their reset values before the next edge.
- With BSG_MCL_SERDES_PKT_COUNTERS_EN, counter preloaded by forcing to 0xFFFFFFFE, 3 packets sent -> tx_pkt_cnt_o[0] = 1.
